// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: counter width,
// address-width helper and the saturating write-counter arithmetic.
package regfile_pkg;

  localparam int WCNT_W = 8;
  localparam logic [WCNT_W-1:0] WCNT_MAX = {WCNT_W{1'b1}};

  // Ceiling log2, usable in parameter defaults.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  // Add up to 7 to the write counter, sticking at all-ones instead of wrapping.
  function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] cnt,
                                                 input logic [2:0]        inc);
    logic [WCNT_W:0] sum;
    sum = {1'b0, cnt} + {{(WCNT_W-2){1'b0}}, inc};
    return sum[WCNT_W] ? WCNT_MAX : sum[WCNT_W-1:0];
  endfunction

endpackage

// File: rtl/regfile_wr_sel.sv
// Resolves all write ports against one register index. The highest-numbered
// enabled port addressing idx_i wins; used for storage update and bypass.
module regfile_wr_sel
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_WR = 1
) (
  input  logic [ADDR_W-1:0]        idx_i,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  output logic                     hit_o,
  output logic [DATA_W-1:0]        data_o
);

  // Later iterations overwrite earlier ones, giving highest-index priority.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] == idx_i)) begin
        hit_o  = 1'b1;
        data_o = wr_data_i[w*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard for RAW stalls.
// Register 0 is not stored: it reads as zero, is never busy, and writes or
// allocs to it are dropped.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ADDR_W   = clog2(NUM_REGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic                     alloc_en_i,
  input  logic [ADDR_W-1:0]        alloc_addr_i,
  input  logic                     flush_i,
  output logic [WCNT_W-1:0]        wr_cnt_o
);

  localparam bit BYP_EN = (BYPASS != 0);

  // Full-size views of stored state; entry 0 is the constant-zero register.
  logic [DATA_W-1:0]   data_view [NUM_REGS];
  logic [NUM_REGS-1:0] busy_view;

  assign data_view[0] = '0;
  assign busy_view[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;

    regfile_wr_sel #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_wr_sel (
      .idx_i     (ADDR_W'(r)),
      .wr_en_i   (wr_en_i),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .hit_o     (hit),
      .data_o    (hit_data)
    );

    // Next data: winning write, otherwise hold.
    always_comb begin
      data_d = hit ? hit_data : data_q;
    end

    // Busy priority: flush clears, alloc sets (new producer owns it), write-back clears.
    always_comb begin
      busy_d = busy_q;
      if (flush_i) begin
        busy_d = 1'b0;
      end else if (alloc_en_i && (alloc_addr_i == ADDR_W'(r))) begin
        busy_d = 1'b1;
      end else if (hit) begin
        busy_d = 1'b0;
      end
    end

    // Register data and busy state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else begin
        data_q <= data_d;
        busy_q <= busy_d;
      end
    end

    assign data_view[r] = data_q;
    assign busy_view[r] = busy_q;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr = rd_addr_i[p*ADDR_W +: ADDR_W];

    regfile_wr_sel #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_byp_sel (
      .idx_i     (addr),
      .wr_en_i   (wr_en_i),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .hit_o     (byp_hit),
      .data_o    (byp_data)
    );

    // Read mux: zero register, then bypass (suppressed in reset), then storage.
    // A bypassed value is a completed write-back, so busy only shows if a
    // new producer is allocated to the same register this cycle.
    always_comb begin
      data = '0;
      busy = 1'b0;
      if (addr != '0) begin
        if (BYP_EN && rst_ni && byp_hit) begin
          data = byp_data;
          busy = alloc_en_i && (alloc_addr_i == addr);
        end else begin
          data = data_view[addr];
          busy = busy_view[addr];
        end
      end
    end

    assign rd_data_o[p*DATA_W +: DATA_W] = data;
    assign rd_busy_o[p]                  = busy;
  end

  // Diagnostic count of writes to non-zero registers, saturating.
  logic [2:0]        wr_num;
  logic [WCNT_W-1:0] wr_cnt_q, wr_cnt_d;

  // Count committed writes this cycle; each enabled port counts separately.
  always_comb begin
    wr_num = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] != '0)) begin
        wr_num = wr_num + 3'd1;
      end
    end
    wr_cnt_d = sat_inc(wr_cnt_q, wr_num);
  end

  // Write counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: two instances share every input, one without bypass (a) and
// one with bypass (b), both with two write ports. Expectations are queued as
// stimulus is applied and consumed in order as outputs are sampled.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_a, rd_data_b;
  logic [NR-1:0]    busy_a, busy_b;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic             flush;
  logic [7:0]       cnt_a, cnt_b;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .NUM_REGS(32), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a),
    .rd_busy_o(busy_a), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .flush_i(flush), .wr_cnt_o(cnt_a)
  );

  regfile_mp #(.DATA_W(DW), .NUM_REGS(32), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
    .rd_busy_o(busy_b), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .flush_i(flush), .wr_cnt_o(cnt_b)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endfunction

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed %h required an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [31:0] da(input int p);
    return rd_data_a[p*DW +: DW];
  endfunction
  function automatic logic [31:0] db(input int p);
    return rd_data_b[p*DW +: DW];
  endfunction
  function automatic logic [31:0] ba(input int p);
    return {31'b0, busy_a[p]};
  endfunction
  function automatic logic [31:0] bb(input int p);
    return {31'b0, busy_b[p]};
  endfunction

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[port]               = 1'b1;
    wr_addr[port*AW +: AW]    = a;
    wr_data[port*DW +: DW]    = d;
  endtask

  task automatic rd(input int port, input logic [AW-1:0] a);
    rd_addr[port*AW +: AW] = a;
  endtask

  task automatic alloc(input logic [AW-1:0] a);
    alloc_en   = 1'b1;
    alloc_addr = a;
  endtask

  task automatic idle();
    wr_en    = '0;
    alloc_en = 1'b0;
    flush    = 1'b0;
  endtask

  // Advance one clock; return 2 time units after the edge with inputs idle.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;

    // Writes during reset are ignored and reads stay zero (bypass too).
    #2;
    wr(0, 5'd5, 32'hDEADBEEF); rd(0, 5'd5);
    push("rst_rd_a", 32'h0); push("rst_rd_b", 32'h0);
    @(posedge clk); #3;
    chk(da(0)); chk(db(0));
    @(posedge clk); #1; idle(); rst_n = 1'b1; #1;
    push("rel_rd_a", 32'h0); push("rel_busy_a", 32'h0);
    push("rel_cnt_a", 32'h0); push("rel_cnt_b", 32'h0);
    chk(da(0)); chk(ba(0)); chk(32'(cnt_a)); chk(32'(cnt_b));

    // Basic write r7: not visible before the edge without bypass, visible with it.
    wr(0, 5'd7, 32'h12345678); rd(0, 5'd7);
    push("r7_pre_a", 32'h0); push("r7_byp_b", 32'h12345678);
    push("r7_post_a", 32'h12345678); push("r7_cnt_a", 32'd1);
    #3; chk(da(0)); chk(db(0));
    step(); chk(da(0)); chk(32'(cnt_a));

    // Write to r0 is dropped and not counted.
    wr(0, 5'd0, 32'hFFFFFFFF); rd(0, 5'd0);
    push("r0_byp_b", 32'h0); push("r0_post_a", 32'h0); push("r0_cnt_a", 32'd1);
    #3; chk(db(0));
    step(); chk(da(0)); chk(32'(cnt_a));

    // Bypass on read port 1.
    wr(0, 5'd3, 32'hA5A5A5A5); rd(1, 5'd3);
    push("r3_pre_a", 32'h0); push("r3_byp_b", 32'hA5A5A5A5);
    push("r3_post_a", 32'hA5A5A5A5); push("r3_cnt_a", 32'd2);
    #3; chk(da(1)); chk(db(1));
    step(); chk(da(1)); chk(32'(cnt_a));

    // Dual write to r9: port 1 wins, both writes counted.
    wr(0, 5'd9, 32'h1); wr(1, 5'd9, 32'h2); rd(0, 5'd9);
    push("r9_byp_b", 32'h2); push("r9_post_a", 32'h2);
    push("r9_post_b", 32'h2); push("r9_cnt_a", 32'd4);
    #3; chk(db(0));
    step(); chk(da(0)); chk(db(0)); chk(32'(cnt_a));

    // Alloc r4: busy appears the cycle after.
    alloc(5'd4); rd(0, 5'd4);
    push("alloc_pre_a", 32'h0); push("alloc_post_a", 32'h1); push("alloc_post_b", 32'h1);
    #3; chk(ba(0));
    step(); chk(ba(0)); chk(bb(0));

    // Write-back r4 clears busy; bypassed read masks busy.
    wr(0, 5'd4, 32'h44);
    push("wb_pre_a", 32'h1); push("wb_mask_b", 32'h0);
    push("wb_post_a", 32'h0); push("wb_data_a", 32'h44); push("wb_cnt_a", 32'd5);
    #3; chk(ba(0)); chk(bb(0));
    step(); chk(ba(0)); chk(da(0)); chk(32'(cnt_a));

    // Alloc and write-back to r4 together: alloc wins, busy stays set.
    alloc(5'd4); wr(0, 5'd4, 32'h55);
    push("aw_mask_b", 32'h1); push("aw_post_a", 32'h1); push("aw_data_a", 32'h55);
    #3; chk(bb(0));
    step(); chk(ba(0)); chk(da(0));

    // Alloc r0 is dropped.
    alloc(5'd0); rd(1, 5'd0);
    push("alloc0_a", 32'h0);
    step(); chk(ba(1));

    // Alloc r1..r3 over three cycles, then flush with a same-cycle alloc r6.
    alloc(5'd1); rd(0, 5'd1);
    push("a1_busy", 32'h1);
    step(); chk(ba(0));
    alloc(5'd2); step();
    alloc(5'd3); rd(1, 5'd2);
    push("a2_busy", 32'h1);
    step(); chk(ba(1));
    flush = 1'b1; alloc(5'd6);
    step();
    rd(0, 5'd1); rd(1, 5'd2); #1;
    push("fl_r1", 32'h0); push("fl_r2", 32'h0);
    chk(ba(0)); chk(ba(1));
    rd(0, 5'd3); rd(1, 5'd6); #1;
    push("fl_r3", 32'h0); push("fl_r6", 32'h0);
    chk(ba(0)); chk(ba(1));
    rd(0, 5'd4); #1;
    push("fl_r4", 32'h0);
    chk(ba(0));

    // Saturation: counter sits at 6 here; 300 more writes must stop at 255.
    for (int i = 0; i < 300; i++) begin
      wr(0, 5'd10, 32'(i));
      step();
      if (i == 247) begin
        push("sat_254", 32'd254);
        chk(32'(cnt_a));
      end
      if (i == 248) begin
        push("sat_255", 32'd255);
        chk(32'(cnt_a));
      end
    end
    rd(0, 5'd10); #1;
    push("sat_cnt_a", 32'd255); push("sat_cnt_b", 32'd255); push("r10_last", 32'd299);
    chk(32'(cnt_a)); chk(32'(cnt_b)); chk(da(0));

    // Mid-operation async reset clears everything at once; in-flight write lost.
    rd(0, 5'd7); rd(1, 5'd10); wr(0, 5'd11, 32'h77);
    #3; rst_n = 1'b0; #1;
    push("mrst_r7_a", 32'h0); push("mrst_r10_b", 32'h0);
    push("mrst_cnt_a", 32'h0); push("mrst_cnt_b", 32'h0);
    chk(da(0)); chk(db(1)); chk(32'(cnt_a)); chk(32'(cnt_b));
    @(posedge clk); #1; idle(); rst_n = 1'b1; #1;
    rd(0, 5'd11); #1;
    push("mrst_r11_a", 32'h0); push("mrst_cnt_after", 32'h0);
    chk(da(0)); chk(32'(cnt_a));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
